sha256_msg_schedule: RTL and testbench

//   Downstream of the message splitter. Takes one 512-bit SHA-256 block
//   (16 x 32-bit words) and streams the 64-word message schedule W[0..63],
//   one word per beat, to the compression-round stage. A 16-entry ring

---
 rtl/sha256_pkg.sv | 48 ++++
 rtl/sha256_msg_schedule.sv | 180 ++++++++++++++++++
 tb/tb_sha256_msg_schedule.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
//   Shared SHA-256 definitions for the message schedule and the round stage:
//   block/schedule sizes, the schedule FSM state encoding, the small-sigma
//   functions s0/s1 and the 64-entry round constant table K.
// ---------------------------------------------------------------------------
package sha256_pkg;

   localparam int WORDS_PER_BLK = 16;
   localparam int SCHED_LEN     = 64;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } sched_state_e;

   // Round constants; not used by the schedule itself, kept here so the
   // compression-round stage shares one copy.
   localparam logic [31:0] SHA256_K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
   function automatic logic [31:0] sha256_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
   function automatic logic [31:0] sha256_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// sha256_msg_schedule
//   Accepts one 512-bit SHA-256 block and streams the 64-word message
//   schedule W[0..63], one word per beat, using a 16-entry ring buffer.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   blk_valid/blk_ready   block handshake; blk_data word 0 = [511:480]
//   w_valid/w_ready       schedule word handshake
//   w_data, w_idx, w_last W[t], t, and (t == 63)
//   busy                  a block is being streamed
//   blk_cnt               completed-block counter, wraps at 16 bits
//                         (only with SHA_SCHED_BLKCNT_EN defined)
//
// Configuration macro: SHA_SCHED_BLKCNT_EN
// ---------------------------------------------------------------------------
module sha256_msg_schedule
   import sha256_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int NUM_ROUNDS = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              blk_valid,
   output logic                              blk_ready,
   input  logic [WORDS_PER_BLK*WORD_W-1:0]   blk_data,
   output logic                              w_valid,
   input  logic                              w_ready,
   output logic [WORD_W-1:0]                 w_data,
   output logic [5:0]                        w_idx,
   output logic                              w_last,
`ifdef SHA_SCHED_BLKCNT_EN
   output logic [15:0]                       blk_cnt,
`endif
   output logic                              busy
);

   localparam logic [5:0] LAST_IDX  = 6'(NUM_ROUNDS - 1);
   localparam logic [5:0] FIRST_GEN = 6'(WORDS_PER_BLK);

   sched_state_e        state_q, state_d;
   logic                blk_ready_q, blk_ready_d;
   logic                w_valid_q, w_valid_d;
   logic                w_last_q, w_last_d;
   logic [WORD_W-1:0]   w_data_q, w_data_d;
   logic [5:0]          t_q, t_d;
   logic [WORD_W-1:0]   ring_q [WORDS_PER_BLK];
   logic [WORD_W-1:0]   ring_d [WORDS_PER_BLK];

   logic                accept;
   logic                w_hs;
   logic [5:0]          t_nxt;
   logic [3:0]          slot_nxt, slot_m2, slot_m7, slot_m15;
   logic [WORD_W-1:0]   w_nxt;

   assign accept = (state_q == ST_IDLE) && blk_ready_q && blk_valid;
   assign w_hs   = w_valid_q && w_ready;

   // Next schedule word. The ring always holds W[t-15..t] (the current word
   // is written back when it is produced), so W[t+1] comes straight from the
   // ring with no bubble. Slot (t+1)&15 still holds W[t-15] = W[(t+1)-16]
   // until it is overwritten on the advancing edge.
   always_comb begin
      t_nxt    = t_q + 6'd1;
      slot_nxt = t_nxt[3:0];
      slot_m2  = slot_nxt - 4'd2;
      slot_m7  = slot_nxt - 4'd7;
      slot_m15 = slot_nxt - 4'd15;
      if (t_nxt < FIRST_GEN) begin
         w_nxt = ring_q[slot_nxt];
      end else begin
         w_nxt = sha256_s1(ring_q[slot_m2]) + ring_q[slot_m7]
               + sha256_s0(ring_q[slot_m15]) + ring_q[slot_nxt];
      end
   end

   // FSM next state and datapath.
   always_comb begin
      state_d     = state_q;
      blk_ready_d = blk_ready_q;
      w_valid_d   = w_valid_q;
      w_last_d    = w_last_q;
      w_data_d    = w_data_q;
      t_d         = t_q;
      ring_d      = ring_q;

      case (state_q)
         ST_IDLE: begin
            blk_ready_d = 1'b1;
            if (accept) begin
               for (int i = 0; i < WORDS_PER_BLK; i++) begin
                  ring_d[i] = blk_data[(WORDS_PER_BLK-1-i)*WORD_W +: WORD_W];
               end
               t_d         = 6'd0;
               w_data_d    = blk_data[(WORDS_PER_BLK-1)*WORD_W +: WORD_W];
               w_valid_d   = 1'b1;
               w_last_d    = 1'b0;
               blk_ready_d = 1'b0;
               state_d     = ST_STREAM;
            end
         end
         ST_STREAM: begin
            blk_ready_d = 1'b0;
            if (w_hs) begin
               if (w_last_q) begin
                  // Ready for the next block on the same edge; the accept
                  // itself happens no earlier than the following cycle.
                  state_d     = ST_IDLE;
                  w_valid_d   = 1'b0;
                  w_last_d    = 1'b0;
                  blk_ready_d = 1'b1;
               end else begin
                  t_d      = t_nxt;
                  w_data_d = w_nxt;
                  w_last_d = (t_nxt == LAST_IDX);
                  if (t_nxt >= FIRST_GEN) begin
                     ring_d[slot_nxt] = w_nxt;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         blk_ready_q <= 1'b0;
         w_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
         w_data_q    <= '0;
         t_q         <= '0;
      end else begin
         state_q     <= state_d;
         blk_ready_q <= blk_ready_d;
         w_valid_q   <= w_valid_d;
         w_last_q    <= w_last_d;
         w_data_q    <= w_data_d;
         t_q         <= t_d;
      end
   end

   // Ring contents are irrelevant after reset: every block reloads all slots.
   always_ff @(posedge clk) begin
      ring_q <= ring_d;
   end

`ifdef SHA_SCHED_BLKCNT_EN
   logic [15:0] blk_cnt_q, blk_cnt_d;

   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if ((state_q == ST_STREAM) && w_hs && w_last_q) begin
         blk_cnt_d = blk_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk_cnt_q <= '0;
      end else begin
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

   assign blk_ready = blk_ready_q;
   assign w_valid   = w_valid_q;
   assign w_last    = w_last_q;
   assign w_data    = w_data_q;
   assign w_idx     = t_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_schedule
//   Directed bench for sha256_msg_schedule: reset values, the "abc" block,
//   stalls, an all-zero block, blk_valid while busy, reset mid-stream and
//   (with SHA_SCHED_BLKCNT_EN) the block counter.
// ---------------------------------------------------------------------------
module tb_sha256_msg_schedule;

   // "abc" padded block: word 0, fourteen zero words, length word 0x18.
   localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_ZERO = '0;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [511:0] blk_data = '0;
   logic         w_valid;
   logic         w_ready = 1'b0;
   logic [31:0]  w_data;
   logic [5:0]   w_idx;
   logic         w_last;
   logic         busy;
`ifdef SHA_SCHED_BLKCNT_EN
   logic [15:0]  blk_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sha256_msg_schedule dut (
      .clk       (clk),
      .rst       (rst),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .w_idx     (w_idx),
      .w_last    (w_last),
`ifdef SHA_SCHED_BLKCNT_EN
      .blk_cnt   (blk_cnt),
`endif
      .busy      (busy)
   );

   // Reference model: plain 64-entry array, straight from the definition.
   typedef logic [31:0] sched_t [64];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic sched_t ref_sched(input logic [511:0] b);
      sched_t w;
      logic [31:0] a, c;
      for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         a = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         c = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = c + w[i-7] + a + w[i-16];
      end
      return w;
   endfunction

   // Results of the last collect() call.
   logic [31:0] got_w   [64];
   logic [5:0]  got_idx [64];
   logic [31:0] abc_got [64];
   int n_got, last_cnt, last_pos, cycles, rdy_busy;
   bit timed_out;

   // Offer a block once blk_ready is seen; leaves the bench at #1 after the
   // accepting edge with blk_valid low and blk_data scrambled.
   task automatic send_block(input logic [511:0] d);
      int n = 0;
      while (!blk_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!blk_ready) begin
         checks++; errors++;
         $display("FAIL send_wait: blk_ready=%b after %0d cycles, want 1", blk_ready, n);
      end
      blk_valid = 1'b1;
      blk_data  = d;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      blk_data  = '1;
   endtask

   // Consume one block. mode 0: always ready. mode 1: 5-cycle stall at t=20,
   // random w_ready afterwards. Checks output stability through every stall.
   task automatic collect(input int mode, input int budget);
      int stall_left = 0;
      bit stalled = 0, hold = 0, done = 0;
      logic [31:0] h_d;
      logic [5:0]  h_i;
      logic        h_l;
      n_got = 0; last_cnt = 0; last_pos = -1; cycles = 0; rdy_busy = 0; timed_out = 0;
      while (!done) begin
         if (hold) begin
            checks++;
            if (w_valid !== 1'b1 || w_data !== h_d || w_idx !== h_i || w_last !== h_l) begin
               errors++;
               $display("FAIL stall_hold: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                        w_valid, w_data, w_idx, w_last, h_d, h_i, h_l);
            end
         end
         if (mode == 1 && !stalled && w_valid && w_idx == 6'd20) begin
            stall_left = 5; stalled = 1;
         end
         if (stall_left > 0) begin
            w_ready = 1'b0; stall_left--;
         end else if (mode == 1 && stalled) begin
            w_ready = 1'($urandom_range(0, 1));
         end else begin
            w_ready = 1'b1;
         end
         if (busy && blk_ready) rdy_busy++;
         hold = w_valid && !w_ready;
         h_d = w_data; h_i = w_idx; h_l = w_last;
         if (w_valid && w_ready) begin
            if (n_got < 64) begin
               got_w[n_got]   = w_data;
               got_idx[n_got] = w_idx;
            end
            if (w_last) begin
               last_cnt++; last_pos = n_got; done = 1;
            end
            n_got++;
         end
         @(posedge clk); #1;
         cycles++;
         if (!done && cycles >= budget) begin
            timed_out = 1; done = 1;
         end
      end
      w_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (blk_ready !== 1'b0 || w_valid !== 1'b0 || w_last !== 1'b0 || busy !== 1'b0 ||
          w_data !== 32'h0 || w_idx !== 6'd0) begin
         errors++;
         $display("FAIL reset_vals: rdy=%b v=%b l=%b busy=%b d=%h i=%0d, want all 0",
                  blk_ready, w_valid, w_last, busy, w_data, w_idx);
      end
      @(posedge clk); #1;
      checks++;
      if (blk_ready !== 1'b0) begin
         errors++; $display("FAIL reset_held_rdy: blk_ready=%b want 0", blk_ready);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (blk_ready !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b busy=%b v=%b, want 1 0 0", blk_ready, busy, w_valid);
      end
   endtask

   task automatic test_abc();
      sched_t r = ref_sched(BLK_ABC);
      send_block(BLK_ABC);
      checks++;
      if (w_valid !== 1'b1 || w_idx !== 6'd0 || w_data !== 32'h61626380 || w_last !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abc_latency: v=%b i=%0d d=%h l=%b busy=%b, want 1 0 61626380 0 1",
                  w_valid, w_idx, w_data, w_last, busy);
      end
      collect(0, 200);
      checks++;
      if (timed_out || n_got != 64 || cycles != 64) begin
         errors++;
         $display("FAIL abc_count: words=%0d cycles=%0d timeout=%0d, want 64 64 0", n_got, cycles, timed_out);
      end
      checks++;
      if (last_cnt != 1 || last_pos != 63) begin
         errors++; $display("FAIL abc_last: count=%0d beat=%0d, want 1 63", last_cnt, last_pos);
      end
      checks++;
      if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018 ||
          got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000) begin
         errors++;
         $display("FAIL abc_hand: W0=%h W15=%h W16=%h W17=%h, want 61626380 00000018 61626380 000f0000",
                  got_w[0], got_w[15], got_w[16], got_w[17]);
      end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (got_w[i] !== r[i] || got_idx[i] !== 6'(i)) begin
            errors++;
            $display("FAIL abc_word[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_idx[i], r[i], i);
         end
         abc_got[i] = got_w[i];
      end
      checks++;
      if (blk_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abc_end: rdy=%b v=%b busy=%b, want 1 0 0", blk_ready, w_valid, busy);
      end
   endtask

   task automatic test_stall();
      sched_t r = ref_sched(BLK_ABC);
      send_block(BLK_ABC);
      collect(1, 2000);
      checks++;
      if (timed_out || n_got != 64 || last_cnt != 1 || cycles < 69) begin
         errors++;
         $display("FAIL stall_count: words=%0d last=%0d cycles=%0d timeout=%0d, want 64 1 >=69 0",
                  n_got, last_cnt, cycles, timed_out);
      end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (got_w[i] !== r[i] || got_w[i] !== abc_got[i] || got_idx[i] !== 6'(i)) begin
            errors++;
            $display("FAIL stall_word[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_idx[i], r[i], i);
         end
      end
   endtask

   task automatic test_zero();
      send_block(BLK_ZERO);
      collect(0, 200);
      checks++;
      if (timed_out || n_got != 64 || last_cnt != 1 || last_pos != 63) begin
         errors++;
         $display("FAIL zero_count: words=%0d last=%0d beat=%0d, want 64 1 63", n_got, last_cnt, last_pos);
      end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (got_w[i] !== 32'h0 || got_idx[i] !== 6'(i)) begin
            errors++;
            $display("FAIL zero_word[%0d]: got %h idx %0d, want 00000000 idx %0d", i, got_w[i], got_idx[i], i);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [511:0] blk_b;
      sched_t rb, ra;
      for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = 32'hA5A50000 + 32'(i * 3);
      rb = ref_sched(blk_b);
      ra = ref_sched(BLK_ABC);
      while (!blk_ready) begin @(posedge clk); #1; end
      blk_valid = 1'b1;
      blk_data  = BLK_ABC;
      @(posedge clk); #1;
      blk_data  = blk_b;
      checks++;
      if (blk_ready !== 1'b0 || busy !== 1'b1 || w_data !== 32'h61626380) begin
         errors++;
         $display("FAIL busy_start: rdy=%b busy=%b d=%h, want 0 1 61626380", blk_ready, busy, w_data);
      end
      collect(0, 200);
      checks++;
      if (rdy_busy != 0 || n_got != 64 || timed_out) begin
         errors++;
         $display("FAIL busy_rdy: ready-while-busy=%0d words=%0d, want 0 64", rdy_busy, n_got);
      end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (got_w[i] !== ra[i]) begin
            errors++; $display("FAIL busy_abc_word[%0d]: got %h want %h", i, got_w[i], ra[i]);
         end
      end
      checks++;
      if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
         errors++; $display("FAIL busy_end: rdy=%b v=%b, want 1 0", blk_ready, w_valid);
      end
      @(posedge clk); #1;
      blk_valid = 1'b0;
      checks++;
      if (w_valid !== 1'b1 || w_data !== 32'hA5A50000 || w_idx !== 6'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_accept: v=%b d=%h i=%0d busy=%b, want 1 a5a50000 0 1", w_valid, w_data, w_idx, busy);
      end
      collect(0, 200);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (got_w[i] !== rb[i] || got_idx[i] !== 6'(i)) begin
            errors++;
            $display("FAIL busy_b_word[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_idx[i], rb[i], i);
         end
      end
   endtask

   task automatic test_reset_mid();
      sched_t r = ref_sched(BLK_ABC);
      int n = 0;
      send_block(BLK_ABC);
      w_ready = 1'b1;
      while (w_idx != 6'd30 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (w_idx !== 6'd30 || w_data !== r[30]) begin
         errors++; $display("FAIL mid_reach: idx=%0d d=%h, want 30 %h", w_idx, w_data, r[30]);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (w_valid !== 1'b0 || blk_ready !== 1'b0 || busy !== 1'b0 || w_idx !== 6'd0 ||
          w_data !== 32'h0 || w_last !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: v=%b rdy=%b busy=%b i=%0d d=%h l=%b, want all 0",
                  w_valid, blk_ready, busy, w_idx, w_data, w_last);
      end
      w_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      send_block(BLK_ABC);
      checks++;
      if (w_valid !== 1'b1 || w_idx !== 6'd0 || w_data !== 32'h61626380) begin
         errors++;
         $display("FAIL mid_restart: v=%b i=%0d d=%h, want 1 0 61626380", w_valid, w_idx, w_data);
      end
      collect(0, 200);
      checks++;
      if (timed_out || n_got != 64 || cycles != 64 || last_cnt != 1) begin
         errors++;
         $display("FAIL mid_count: words=%0d cycles=%0d last=%0d, want 64 64 1", n_got, cycles, last_cnt);
      end
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (got_w[i] !== r[i] || got_idx[i] !== 6'(i)) begin
            errors++;
            $display("FAIL mid_word[%0d]: got %h idx %0d, want %h idx %0d", i, got_w[i], got_idx[i], r[i], i);
         end
      end
   endtask

`ifdef SHA_SCHED_BLKCNT_EN
   task automatic test_blkcnt();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (blk_cnt !== 16'h0) begin
         errors++; $display("FAIL cnt_reset: blk_cnt=%h want 0000", blk_cnt);
      end
      for (int b = 0; b < 3; b++) begin
         send_block(BLK_ZERO);
         collect(0, 200);
      end
      checks++;
      if (blk_cnt !== 16'd3) begin
         errors++; $display("FAIL cnt_three: blk_cnt=%h want 0003", blk_cnt);
      end
      force dut.blk_cnt_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.blk_cnt_q;
      checks++;
      if (blk_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL cnt_preload: blk_cnt=%h want ffff", blk_cnt);
      end
      send_block(BLK_ABC);
      collect(0, 200);
      checks++;
      if (blk_cnt !== 16'h0000) begin
         errors++; $display("FAIL cnt_wrap: blk_cnt=%h want 0000", blk_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_abc();
      test_stall();
      test_zero();
      test_busy_ignore();
      test_reset_mid();
`ifdef SHA_SCHED_BLKCNT_EN
      test_blkcnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
